// File: rtl/uart_pkg.sv
// Shared UART package: default word width and receive-FIFO depth used by the
// Transmitter, Receiver, baud_generator and uart_rx_fifo.
package uart_pkg;

  // Default width of one UART data word.
  localparam int unsigned UART_SIZE_DATA  = 8;
  // Default log2 of the receive FIFO depth.
  localparam int unsigned UART_ADDR_WIDTH = 4;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// FIFO storage: DEPTH x SIZE_DATA array with one write port and one registered
// read port. Contents are never reset.
// Ports:
//   clk     - system clock
//   wr_en   - write strobe, stores wr_data at wr_addr
//   wr_addr - write address
//   wr_data - write data
//   rd_en   - read strobe, loads rd_data from rd_addr
//   rd_addr - read address
//   rd_data - registered read data; holds while rd_en is low
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned SIZE_DATA  = UART_SIZE_DATA,
  parameter int unsigned ADDR_WIDTH = UART_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [SIZE_DATA-1:0]  wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [SIZE_DATA-1:0]  rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [SIZE_DATA-1:0] mem_r [DEPTH];

  // Write port and registered read port; a read of the address being written
  // in the same cycle returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART Receiver and the host.
// One word is written per rising edge of i_rx_done; the host pops with i_rd_en
// and gets the word one cycle later with an o_rd_valid pulse. Words arriving
// while full (and not simultaneously popped) are dropped and flagged in the
// sticky o_overrun.
// Ports:
//   i_clk, i_rst_n  - clock, synchronous active-low reset
//   i_rx_done       - receiver end-of-frame strobe (level, edge-detected here)
//   i_rx_data       - receiver data, valid while i_rx_done is high
//   o_fifo_full     - count == DEPTH
//   i_rd_en         - host pop request
//   o_rd_data       - popped word
//   o_rd_valid      - one-cycle pulse qualifying o_rd_data
//   o_fifo_empty    - count == 0
//   o_count         - occupancy 0..DEPTH
//   o_overrun       - sticky dropped-word flag
//   i_clr_overrun   - clears o_overrun (a coincident set wins)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned SIZE_DATA  = UART_SIZE_DATA,
  parameter int unsigned ADDR_WIDTH = UART_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx_done,
  input  logic [SIZE_DATA-1:0]  i_rx_data,
  output logic                  o_fifo_full,
  input  logic                  i_rd_en,
  output logic [SIZE_DATA-1:0]  o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_fifo_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overrun,
  input  logic                  i_clr_overrun
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic                  rx_done_q_r;
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  rd_valid_r;
  logic                  overrun_r;
  // Set once a word has been popped since reset; the storage read register is
  // not reset, so o_rd_data is forced to zero until then.
  logic                  rd_seen_r;
  logic [SIZE_DATA-1:0]  mem_q_s;

  logic                  full_s;
  logic                  empty_s;
  logic                  wr_req_s;
  logic                  rd_req_s;
  logic                  wr_en_s;
  logic                  drop_s;

  // Request decode: rising-edge write, non-empty read; a write into a full
  // FIFO is still accepted when a pop frees a slot in the same cycle.
  always_comb begin
    full_s   = 1'b0;
    empty_s  = 1'b0;
    wr_req_s = 1'b0;
    rd_req_s = 1'b0;
    wr_en_s  = 1'b0;
    drop_s   = 1'b0;
    full_s   = (count_r == DEPTH_C);
    empty_s  = (count_r == {(ADDR_WIDTH+1){1'b0}});
    wr_req_s = i_rx_done & ~rx_done_q_r;
    rd_req_s = i_rd_en & ~empty_s;
    if (wr_req_s) begin
      wr_en_s = ~full_s | rd_req_s;
      drop_s  = full_s & ~rd_req_s;
    end else begin
      wr_en_s = 1'b0;
      drop_s  = 1'b0;
    end
  end

  // Pointer, occupancy, read-valid and overrun state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_done_q_r <= 1'b0;
      wr_ptr_r    <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r    <= {ADDR_WIDTH{1'b0}};
      count_r     <= {(ADDR_WIDTH+1){1'b0}};
      rd_valid_r  <= 1'b0;
      overrun_r   <= 1'b0;
      rd_seen_r   <= 1'b0;
    end else begin
      rx_done_q_r <= i_rx_done;
      rd_valid_r  <= rd_req_s;
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
      end
      if (rd_req_s) begin
        rd_ptr_r  <= rd_ptr_r + ADDR_WIDTH'(1);
        rd_seen_r <= 1'b1;
      end
      case ({wr_en_s, rd_req_s})
        2'b10:   count_r <= count_r + (ADDR_WIDTH+1)'(1);
        2'b01:   count_r <= count_r - (ADDR_WIDTH+1)'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (i_clr_overrun) begin
        overrun_r <= 1'b0;
      end
    end
  end

  uart_fifo_mem #(
    .SIZE_DATA  (SIZE_DATA),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (i_clk),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_r),
    .wr_data (i_rx_data),
    .rd_en   (rd_req_s),
    .rd_addr (rd_ptr_r),
    .rd_data (mem_q_s)
  );

  assign o_rd_data    = rd_seen_r ? mem_q_s : {SIZE_DATA{1'b0}};
  assign o_rd_valid   = rd_valid_r;
  assign o_overrun    = overrun_r;
  assign o_count      = count_r;
  assign o_fifo_full  = full_s;
  assign o_fifo_empty = empty_s;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_rx_done = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       o_fifo_full;
  logic       i_rd_en = 1'b0;
  logic [7:0] o_rd_data;
  logic       o_rd_valid;
  logic       o_fifo_empty;
  logic [4:0] o_count;
  logic       o_overrun;
  logic       i_clr_overrun = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       prev_done = 1'b0;
  logic       m_ovr = 1'b0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;

  uart_rx_fifo dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_rx_done     (i_rx_done),
    .i_rx_data     (i_rx_data),
    .o_fifo_full   (o_fifo_full),
    .i_rd_en       (i_rd_en),
    .o_rd_data     (o_rd_data),
    .o_rd_valid    (o_rd_valid),
    .o_fifo_empty  (o_fifo_empty),
    .o_count       (o_count),
    .o_overrun     (o_overrun),
    .i_clr_overrun (i_clr_overrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the current inputs, then clock the
  // DUT and compare all outputs just after the edge.
  task automatic cycle();
    bit wr, rd;
    int sz;
    if (!i_rst_n) begin
      q.delete();
      prev_done = 1'b0;
      m_ovr     = 1'b0;
      m_valid   = 1'b0;
      m_data    = 8'h00;
    end else begin
      sz = q.size();
      wr = i_rx_done && !prev_done;
      rd = i_rd_en && (sz != 0);
      m_valid = rd;
      if (rd) m_data = q.pop_front();
      if (wr) begin
        if (sz < DEPTH || rd) q.push_back(i_rx_data);
      end
      if (wr && sz == DEPTH && !rd) m_ovr = 1'b1;
      else if (i_clr_overrun) m_ovr = 1'b0;
      prev_done = i_rx_done;
    end
    @(posedge i_clk);
    #1;
    chk("count",   32'(o_count),      32'(q.size()));
    chk("empty",   32'(o_fifo_empty), 32'(q.size() == 0));
    chk("full",    32'(o_fifo_full),  32'(q.size() == DEPTH));
    chk("valid",   32'(o_rd_valid),   32'(m_valid));
    chk("data",    32'(o_rd_data),    32'(m_data));
    chk("overrun", 32'(o_overrun),    32'(m_ovr));
  endtask

  task automatic push(input logic [7:0] d, input int len);
    i_rx_data = d;
    i_rx_done = 1'b1;
    for (int k = 0; k < len; k++) cycle();
    i_rx_done = 1'b0;
    cycle();
  endtask

  task automatic pop();
    i_rd_en = 1'b1;
    cycle();
    i_rd_en = 1'b0;
  endtask

  initial begin
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    cycle();
    cycle();
    chk("rst_empty", 32'(o_fifo_empty), 32'd1);
    chk("rst_count", 32'(o_count), 32'd0);
    i_rst_n = 1'b1;

    // Long strobe writes once, read has 1-cycle latency
    push(8'h29, 3);
    chk("one_write", 32'(o_count), 32'd1);
    pop();
    chk("rd29_valid", 32'(o_rd_valid), 32'd1);
    chk("rd29_data", 32'(o_rd_data), 32'h29);
    cycle();

    // Fill, overrun, drain in order
    for (int i = 0; i < 16; i++) push(8'(i), 1);
    chk("full16", 32'(o_fifo_full), 32'd1);
    push(8'hAA, 1);
    chk("ovr_set", 32'(o_overrun), 32'd1);
    chk("ovr_cnt", 32'(o_count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      pop();
      chk("drain", 32'(o_rd_data), 32'(i));
    end
    cycle();
    i_clr_overrun = 1'b1;
    cycle();
    i_clr_overrun = 1'b0;

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i), 1);
    i_rx_data = 8'h55;
    i_rx_done = 1'b1;
    i_rd_en   = 1'b1;
    cycle();
    i_rx_done = 1'b0;
    i_rd_en   = 1'b0;
    chk("fullrw_data", 32'(o_rd_data), 32'h40);
    chk("fullrw_ovr", 32'(o_overrun), 32'd0);
    chk("fullrw_cnt", 32'(o_count), 32'd16);
    for (int i = 0; i < 16; i++) pop();
    chk("last55", 32'(o_rd_data), 32'h55);
    cycle();

    // Read while empty, then push+read on empty
    pop();
    chk("empty_rd", 32'(o_rd_valid), 32'd0);
    i_rx_data = 8'h3C;
    i_rx_done = 1'b1;
    i_rd_en   = 1'b1;
    cycle();
    i_rx_done = 1'b0;
    i_rd_en   = 1'b0;
    chk("nofall_valid", 32'(o_rd_valid), 32'd0);
    chk("nofall_cnt", 32'(o_count), 32'd1);
    pop();
    cycle();

    // 40 push/pop pairs to wrap pointers
    for (int i = 0; i < 40; i++) begin
      push(8'(i), 1);
      pop();
      chk("wrap", 32'(o_rd_data), 32'(i));
    end
    cycle();

    // Mid-operation reset with count 5 and overrun set
    for (int i = 0; i < 17; i++) push(8'(8'h80 + i), 1);
    for (int i = 0; i < 11; i++) pop();
    cycle();
    chk("pre_rst_cnt", 32'(o_count), 32'd5);
    chk("pre_rst_ovr", 32'(o_overrun), 32'd1);
    i_rd_en = 1'b1;
    i_rst_n = 1'b0;
    cycle();
    i_rst_n = 1'b1;
    i_rd_en = 1'b0;
    chk("rst_valid", 32'(o_rd_valid), 32'd0);

    // Random traffic with phases biased toward filling and draining
    for (int i = 0; i < 600; i++) begin
      int phase;
      phase = (i / 100) % 2;
      i_rx_data     = 8'($urandom);
      i_rx_done     = ($urandom_range(0, 9) < (phase == 0 ? 6 : 3));
      i_rd_en       = ($urandom_range(0, 9) < (phase == 0 ? 2 : 7));
      i_clr_overrun = ($urandom_range(0, 19) == 0);
      i_rst_n       = ($urandom_range(0, 199) != 0);
      cycle();
    end
    i_rst_n = 1'b1;
    i_rx_done = 1'b0;
    i_rd_en = 1'b0;
    i_clr_overrun = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx_fifo
